// File: rtl/rvga_dmem_responder_pkg.sv
// Shared types for the RVGA data-memory responder.
// Holds the FSM state and memory-op enums, the common 32-bit word type,
// and the LFSR reset seed used by the optional stall injector.
package rvga_types;

  typedef logic [31:0] rvga_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rvga_dmem_state_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LD   = 2'd1,
    MEM_ST   = 2'd2
  } rvga_mem_op_e;

  localparam logic [7:0] RVGA_LFSR_SEED = 8'hA5;

  // A simultaneous load+store request is executed as a store.
  function automatic rvga_mem_op_e decode_op(input logic r_v, input logic w_v);
    if (w_v) begin
      return MEM_ST;
    end else if (r_v) begin
      return MEM_LD;
    end else begin
      return MEM_NONE;
    end
  endfunction

endpackage

// File: rtl/rvga_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1).
// Only built when RVGA_DMEM_STALL_INJECT_EN is defined; it supplies 0..3
// extra wait cycles per accepted request from its two low bits.
module rvga_lfsr
  import rvga_types::*;
#(
  parameter logic [7:0] SEED = RVGA_LFSR_SEED
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  output logic [1:0] stall_o
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Shift register restarts from the seed on reset and steps once per acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= SEED;
    end else if (adv_i) begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

  assign stall_o = lfsr_q[1:0];

endmodule

// File: rtl/rvga_dmem_responder.sv
// RVGA data-memory responder: a word-addressed memory that accepts one
// held load/store request at a time and answers with a single-cycle
// response pulse LATENCY cycles after acceptance.
// Optional feature: define RVGA_DMEM_STALL_INJECT_EN to add 0..3 random
// wait cycles per request from an rvga_lfsr instance.
module rvga_dmem_responder
  import rvga_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dmem_r_v_i,
  input  logic       dmem_w_v_i,
  input  rvga_word   dmem_addr_i,
  input  rvga_word   dmem_data_i,
  output rvga_word   dmem_data_o,
  output logic       dmem_resp_v_o,
  output logic       err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough for LATENCY-1 (max 14) plus 3 injected stall cycles.
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] BASE_WAIT = CNT_W'(LATENCY - 1);

  rvga_dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rvga_mem_op_e     op_q;
  logic [IDX_W-1:0] idx_q;
  rvga_word         wdata_q;
  rvga_word         rdata_q;
  logic             err_q;

  rvga_word         mem [DEPTH_WORDS];

  logic             req_v;
  logic             accept;
  rvga_mem_op_e     req_op;
  logic [IDX_W-1:0] req_idx;
  logic             req_bad;
  logic [1:0]       stall_extra;
  logic [CNT_W-1:0] total_wait;

  logic             enter_resp;
  rvga_mem_op_e     exec_op;
  logic [IDX_W-1:0] exec_idx;
  rvga_word         exec_data;
  logic             mem_we;
  logic             mem_re;

  // Address bits above the word index wrap, so they are intentionally dropped.
  logic             addr_hi_unused;
  assign addr_hi_unused = ^dmem_addr_i[31:IDX_W+2];

  assign req_v   = dmem_r_v_i | dmem_w_v_i;
  assign accept  = (state_q == IDLE) && req_v;
  assign req_op  = decode_op(dmem_r_v_i, dmem_w_v_i);
  assign req_idx = dmem_addr_i[IDX_W+1:2];
  assign req_bad = (dmem_r_v_i && dmem_w_v_i) || (dmem_addr_i[1:0] != 2'b00);

`ifdef RVGA_DMEM_STALL_INJECT_EN
  rvga_lfsr #(
    .SEED (RVGA_LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .adv_i   (accept),
    .stall_o (stall_extra)
  );
`else
  assign stall_extra = 2'b00;
`endif

  assign total_wait = BASE_WAIT + {{(CNT_W-2){1'b0}}, stall_extra};

  // Advance the IDLE/WAIT/RESP sequence; the counter holds the WAIT cycles still to go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_v) begin
          if (total_wait == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = total_wait - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and wait counter register; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch op, word index and store data when a request is accepted in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q    <= MEM_NONE;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      idx_q   <= req_idx;
      wdata_q <= dmem_data_i;
    end
  end

  // With a one-cycle path IDLE goes straight to RESP, so the live request
  // must be used on that edge because nothing has been captured yet.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign exec_op    = (state_q == IDLE) ? req_op      : op_q;
  assign exec_idx   = (state_q == IDLE) ? req_idx     : idx_q;
  assign exec_data  = (state_q == IDLE) ? dmem_data_i : wdata_q;
  assign mem_we     = enter_resp && (exec_op == MEM_ST);
  assign mem_re     = enter_resp && (exec_op == MEM_LD);

  // Storage array keeps its contents through reset; reset only blocks writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
    end else if (mem_we) begin
      mem[exec_idx] <= exec_data;
    end
  end

  // Load data is registered on the edge entering RESP and held until the next load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem[exec_idx];
    end
  end

  // Sticky error: dual-valid or misaligned request seen at acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (accept && req_bad) begin
      err_q <= 1'b1;
    end
  end

  assign dmem_data_o   = rdata_q;
  assign dmem_resp_v_o = (state_q == RESP);
  assign err_o         = err_q;

endmodule

// File: tb/tb_rvga_dmem_responder.sv
// Self-checking bench for rvga_dmem_responder: directed scenarios plus
// randomized loads/stores checked against a plain array reference model.
// Define RVGA_DMEM_STALL_INJECT_EN to also exercise the stall injector.
module tb_rvga_dmem_responder;
  import rvga_types::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk_i  = 1'b0;
  logic        rst_i  = 1'b0;
  logic        r_v    = 1'b0;
  logic        w_v    = 1'b0;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  rvga_word    dmem_data_o;
  logic        dmem_resp_v_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_data;
  bit          ref_err;
  int          lat_log [$];

  always #5 clk_i = ~clk_i;

  rvga_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dmem_r_v_i    (r_v),
    .dmem_w_v_i    (w_v),
    .dmem_addr_i   (addr),
    .dmem_data_i   (wdata),
    .dmem_data_o   (dmem_data_o),
    .dmem_resp_v_o (dmem_resp_v_o),
    .err_o         (err_o)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one held request, wait for its response pulse, then release it mid-RESP.
  task automatic apply_stimulus(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, output int lat,
                                output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk_i);
    r_v = r; w_v = w; addr = a; wdata = d;
    n = 0; lat = -1; rdata = 'x; err = 'x;
    while (n < 40 && lat < 0) begin
      @(posedge clk_i); #1; n++;
      if (dmem_resp_v_o === 1'b1) begin
        lat = n; rdata = dmem_data_o; err = err_o;
      end
    end
    @(negedge clk_i);
    r_v = 1'b0; w_v = 1'b0;
  endtask

  // Update the reference model for one request, run it, and compare.
  task automatic do_op(input string tag, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    int          idx, lat;
    logic [31:0] rdata;
    logic        err;
    idx = int'((a >> 2) % DEPTH);
    if ((r && w) || (a[1:0] != 2'b00)) ref_err = 1'b1;
    if (w) ref_mem[idx] = d;
    else   ref_data = ref_mem[idx];
    apply_stimulus(r, w, a, d, lat, rdata, err);
    lat_log.push_back(lat);
`ifdef RVGA_DMEM_STALL_INJECT_EN
    check_output({tag, "_latrange"}, 32'((lat >= int'(LAT)) && (lat <= int'(LAT) + 3)), 32'd1);
`else
    check_output({tag, "_lat"}, lat, LAT);
`endif
    check_output({tag, "_data"}, rdata, ref_data);
    check_output({tag, "_err"}, err, ref_err);
  endtask

  // Pulse reset, check the forced output values, and clear the model's registers.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; r_v = 1'b0; w_v = 1'b0;
    #1;
    check_output("rst_resp", dmem_resp_v_o, 1'b0);
    check_output("rst_data", dmem_data_o, 32'h0);
    check_output("rst_err", err_o, 1'b0);
    ref_data = '0; ref_err = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int          t1, t2, n, pulses;
    logic [31:0] d1, d2, a;
    int          run1 [$];

    ref_data = '0; ref_err = 1'b0;
    #1;
    check_output("init_resp", dmem_resp_v_o, 1'b0);
    check_output("init_data", dmem_data_o, 32'h0);
    check_output("init_err", err_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Store then load at 0x10.
    do_op("st_dead", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_op("ld_dead", 1'b1, 1'b0, 32'h10, 32'h0);
    check_output("ld_dead_const", dmem_data_o, 32'hDEADBEEF);

    // Back-to-back loads with valid held continuously.
    do_op("st_w0", 1'b0, 1'b1, 32'h0, 32'hA0A0_0001);
    do_op("st_w1", 1'b0, 1'b1, 32'h4, 32'hB1B1_0002);
    @(negedge clk_i);
    r_v = 1'b1; addr = 32'h0;
    n = 0; t1 = -1; t2 = -1; d1 = 'x; d2 = 'x;
    while (n < 60 && t2 < 0) begin
      @(posedge clk_i); #1; n++;
      if (dmem_resp_v_o === 1'b1) begin
        if (t1 < 0) begin
          t1 = n; d1 = dmem_data_o;
          @(negedge clk_i);
          addr = 32'h4;
        end else begin
          t2 = n; d2 = dmem_data_o;
        end
      end
    end
    @(negedge clk_i);
    r_v = 1'b0;
    ref_data = 32'hB1B1_0002;
    check_output("b2b_data0", d1, 32'hA0A0_0001);
    check_output("b2b_data1", d2, 32'hB1B1_0002);
    check_output("b2b_seen", 32'(t2 > 0), 32'd1);
`ifndef RVGA_DMEM_STALL_INJECT_EN
    check_output("b2b_first_lat", t1, LAT);
    check_output("b2b_gap", t2 - t1, LAT + 1);
`endif

    // Address wrap: 0x1000 aliases word 0 in a 1024-word memory.
    do_op("st_wrap", 1'b0, 1'b1, 32'h1000, 32'h1234);
    do_op("ld_wrap", 1'b1, 1'b0, 32'h0, 32'h0);
    check_output("ld_wrap_const", dmem_data_o, 32'h1234);

    // Randomized aligned traffic over 16 words with random alias bits.
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2);
      do_op("rnd_init", 1'b0, 1'b1, a, $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 1) == 1) do_op("rnd_st", 1'b0, 1'b1, a, $urandom);
      else                           do_op("rnd_ld", 1'b1, 1'b0, a, 32'h0);
    end

    // Reset while a store sits in WAIT: it must vanish without writing.
    do_op("st_aa", 1'b0, 1'b1, 32'h20, 32'hAA);
    @(negedge clk_i);
    w_v = 1'b1; addr = 32'h20; wdata = 32'hFF;
    @(posedge clk_i); #1;
    check_output("rstw_pre_resp", dmem_resp_v_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check_output("rstw_resp", dmem_resp_v_o, 1'b0);
    check_output("rstw_data", dmem_data_o, 32'h0);
    w_v = 1'b0;
    ref_data = '0; ref_err = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (dmem_resp_v_o === 1'b1) pulses++;
    end
    check_output("rstw_no_pulse", pulses, 0);
    do_op("rstw_ld", 1'b1, 1'b0, 32'h20, 32'h0);
    check_output("rstw_ld_const", dmem_data_o, 32'hAA);

    // Error cases: dual valid executes as store; misaligned load ignores low bits.
    do_op("err_dual", 1'b1, 1'b1, 32'h8, 32'h55);
    do_op("err_dual_ld", 1'b1, 1'b0, 32'h8, 32'h0);
    check_output("err_dual_const", dmem_data_o, 32'h55);
    do_op("err_mis_ld", 1'b1, 1'b0, 32'h6, 32'h0);
    check_output("err_mis_const", dmem_data_o, 32'hB1B1_0002 ^ 32'h0 ^ ref_mem[1] ^ 32'hB1B1_0002);
    do_op("err_sticky", 1'b1, 1'b0, 32'h10, 32'h0);
    do_reset();
    check_output("err_cleared", err_o, 1'b0);

`ifdef RVGA_DMEM_STALL_INJECT_EN
    // Two runs from reset must yield the same latency sequence.
    lat_log.delete();
    for (int i = 0; i < 64; i++) do_op("stall_r1", 1'b1, 1'b0, 32'(i % 16) << 2, 32'h0);
    run1 = lat_log;
    do_reset();
    lat_log.delete();
    for (int i = 0; i < 64; i++) do_op("stall_r2", 1'b1, 1'b0, 32'(i % 16) << 2, 32'h0);
    for (int i = 0; i < 64; i++) check_output("stall_repeat", lat_log[i], run1[i]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvga_dmem_responder.md
RVGA_DMEM_RESPONDER -- requirements
Module: rvga_dmem_responder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 4.
REQ-003 Parameter LATENCY, 2, cycles from request acceptance to dmem_resp_v_o; range 1..15.
REQ-004 clk_i  input  1  clock; all state changes on rising edge.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 dmem_r_v_i  input  1  load request valid; held by initiator until response.
REQ-007 dmem_w_v_i  input  1  store request valid; held by initiator until response.
REQ-008 dmem_addr_i  input  32  byte address of request.
REQ-009 dmem_data_i  input  32  store data.
REQ-010 dmem_data_o  output  32  load data, valid when dmem_resp_v_o=1.
REQ-011 dmem_resp_v_o  output  1  one-cycle response pulse completing the request.
REQ-012 err_o  output  1  sticky protocol-error flag.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
- IDLE -> WAIT on (r_v|w_v) when LATENCY>1.
- IDLE -> RESP when LATENCY=1.
- WAIT -> RESP when the wait counter reaches zero.
- RESP -> IDLE unconditionally.
REQ-014 In IDLE, any asserted request SHALL be treated as new and captured (op, addr, store data); inputs in WAIT/RESP SHALL be ignored.
REQ-015 dmem_resp_v_o SHALL be 1 exactly in the RESP cycle, which is LATENCY cycles after the acceptance cycle (acceptance = cycle 0).
REQ-016 A request asserted in the cycle after RESP SHALL be accepted as a new request; back-to-back requests therefore cost LATENCY+1 cycles each.
REQ-017 Word index SHALL be captured addr[$clog2(DEPTH_WORDS)+1:2]; higher address bits SHALL wrap modulo DEPTH_WORDS.
REQ-018 Store SHALL write the captured data on the clock edge entering RESP; a load SHALL register mem[index] on that same edge and drive it on dmem_data_o during RESP.
REQ-019 dmem_data_o SHALL hold its last value outside RESP; a store response SHALL leave dmem_data_o unchanged.
REQ-020 r_v and w_v both high at acceptance SHALL execute as a store and set err_o.
REQ-021 addr[1:0] != 0 at acceptance SHALL set err_o; the access SHALL still proceed with the low bits ignored.
REQ-022 err_o SHALL clear only on reset.

Reset
REQ-023 rst_i low SHALL immediately force:
- state IDLE;
- dmem_resp_v_o=0, dmem_data_o=0, err_o=0;
- wait counter=0;
- captured request cleared.
REQ-024 A request in flight at reset SHALL be discarded (no write); memory array contents SHALL be retained through reset.

Configuration
REQ-025 With RVGA_DMEM_STALL_INJECT_EN defined, each accepted request SHALL add 0..3 extra WAIT cycles, taken from the two LSBs of an 8-bit maximal LFSR. The LFSR SHALL have reset seed 8'hA5 and SHALL advance once per acceptance.
REQ-026 Without RVGA_DMEM_STALL_INJECT_EN, latency SHALL be exactly LATENCY and no LFSR SHALL exist.

Structure
REQ-027 Package rvga_types SHALL hold rvga_dmem_state_e (IDLE, WAIT, RESP) and rvga_mem_op_e (MEM_NONE, MEM_LD, MEM_ST); rvga_word SHALL be reused for data and address.
REQ-028 The LFSR SHALL be sub-module rvga_lfsr, instantiated only when RVGA_DMEM_STALL_INJECT_EN is defined.

Verification
REQ-029 Store-then-load, LATENCY=2:
- stimulus: store 32'hDEADBEEF to 0x10, then load 0x10;
- response: each resp_v exactly 2 cycles after acceptance; load returns 32'hDEADBEEF.
REQ-030 Back-to-back loads to 0x0 and 0x4, request held high continuously:
- response: two resp_v pulses 3 cycles apart, correct data each.
REQ-031 Wrap, DEPTH_WORDS=1024:
- stimulus: store 32'h1234 to 0x1000, then load 0x0;
- response: load returns 32'h1234.
REQ-032 Error cases:
- r_v=w_v=1 with 32'h55 at 0x8 -> store performed, err_o=1 until reset;
- load at 0x6 -> data of word 0x4, err_o=1.
REQ-033 Reset in WAIT during a store of 32'hFF to 0x20 -> resp_v never pulses, mem[0x20] keeps its old value, FSM resumes in IDLE.
REQ-034 With RVGA_DMEM_STALL_INJECT_EN, 64 loads -> every latency lies in LATENCY..LATENCY+3; the latency sequence is identical across two runs from reset.
